// File: rtl/key_pkg.sv
// Shared constants and FSM state encoding for the 16-key pad front end.
package key_pkg;

    localparam int NKEYS = 16;
    localparam int KEY_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PUSH = 2'd1,
        S_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/key_fifo.sv
// Small show-ahead FIFO with push/pop/clear; a push while full is only taken
// when a pop happens in the same cycle, otherwise it is reported on drop_o.
module key_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         empty_o,
    output logic         full_o,
    output logic         drop_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_pop, do_push;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign drop_o  = push_i && !do_push && !clear_i;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Pointers are log2(DEPTH) wide, so the increment wraps naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/keyenc.sv
// Combinational lowest-bit-wins priority encoder: bit 0 -> code 0, bit 15 -> code 15.
module keyenc
    import key_pkg::*;
(
    input  logic [NKEYS-1:0] vec_i,
    output logic [KEY_W-1:0] code_o
);

    logic [NKEYS-1:0] first_hot;

    genvar gi;
    generate
        for (gi = 0; gi < NKEYS; gi++) begin : g_first
            if (gi == 0) begin : g_lsb
                assign first_hot[gi] = vec_i[gi];
            end else begin : g_upper
                assign first_hot[gi] = vec_i[gi] & ~(|vec_i[gi-1:0]);
            end
        end
    endgenerate

    // first_hot is one-hot (or zero), so OR-ing the indices yields the code.
    always_comb begin
        code_o = '0;
        for (int i = 0; i < NKEYS; i++) begin
            if (first_hot[i]) begin
                code_o = code_o | KEY_W'(i);
            end
        end
    end

endmodule

// File: rtl/key_scan_ctrl.sv
// Key pad front end: 2-FF sync, debounce, one code per press episode, and a
// show-ahead code queue popped with a valid/ack handshake.
module key_scan_ctrl
    import key_pkg::*;
#(
    parameter int DB_CYCLES  = 50000,
    parameter int DB_W       = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [NKEYS-1:0] keys_i,
    input  logic             clear_i,
    input  logic             key_ack_i,
    output logic             key_valid_o,
    output logic [KEY_W-1:0] key_code_o,
    output logic             key_held_o,
    output logic             fifo_full_o,
    output logic             overflow_o
);

    logic [NKEYS-1:0] sync1_q, sync2_q;
    logic [NKEYS-1:0] cand_q, cand_d;
    logic [NKEYS-1:0] stable_q, stable_d;
    logic [DB_W-1:0]  cnt_q, cnt_d, cnt_inc;
    state_e           state_q, state_d;
    logic             overflow_q, overflow_d;
    logic             push_req;
    logic [KEY_W-1:0] push_code;
    logic             fifo_empty, fifo_full, fifo_drop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= keys_i;
            sync2_q <= sync1_q;
        end
    end

    // The incremented count is compared so the vector is accepted on the
    // DB_CYCLES-th consecutive edge that sees it (load edge included).
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + DB_W'(1);

    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB_W'(DB_CYCLES - 1)) begin
                stable_d = cand_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cand_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
        end else begin
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Changes while held (extra keys, partial release) are ignored until all keys are up.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (stable_q != '0) state_d = S_PUSH;
            S_PUSH:  state_d = S_HOLD;
            S_HOLD:  if (stable_q == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        push_req = 1'b0;
        case (state_q)
            S_PUSH:  push_req = 1'b1;
            default: push_req = 1'b0;
        endcase
    end

    keyenc u_enc (
        .vec_i  (stable_q),
        .code_o (push_code)
    );

    key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (KEY_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (push_req),
        .data_i  (push_code),
        .pop_i   (key_ack_i),
        .data_o  (key_code_o),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .drop_o  (fifo_drop)
    );

    always_comb begin
        overflow_d = overflow_q;
        if (clear_i) begin
            overflow_d = 1'b0;
        end else if (fifo_drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign key_valid_o = !fifo_empty;
    assign fifo_full_o = fifo_full;
    assign key_held_o  = (stable_q != '0);
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Bench for key_scan_ctrl: directed scenarios plus random presses, checked by a
// cycle-level behavioural model feeding a scoreboard queue of expected codes.
module tb_key_scan_ctrl;

    localparam int DB    = 4;
    localparam int DEPTH = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] keys  = '0;
    logic        clear = 1'b0;
    logic        ack   = 1'b0;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic        fifo_full;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    // Scoreboard: codes the model says are in the queue, oldest first.
    int exp_q[$];

    // Model state.
    logic [15:0] m_d1 = '0, m_d2 = '0, m_cand = '0, m_stable = '0;
    int          m_run   = 1;
    bit          m_in_ep = 1'b0;
    bit          m_pend  = 1'b0;
    bit          m_ovf   = 1'b0;
    int          m_pcode = 0;

    always #5 clk = ~clk;

    key_scan_ctrl #(
        .DB_CYCLES  (DB),
        .DB_W       (16),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .keys_i      (keys),
        .clear_i     (clear),
        .key_ack_i   (ack),
        .key_valid_o (key_valid),
        .key_code_o  (key_code),
        .key_held_o  (key_held),
        .fifo_full_o (fifo_full),
        .overflow_o  (overflow)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int lowest(input logic [15:0] v);
        for (int i = 0; i < 16; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    // Reference model: a key vector becomes stable once the synchronised
    // sample has shown it DB edges in a row; a press episode starts when
    // stable leaves zero and its code reaches the queue two edges later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_d1 = '0; m_d2 = '0; m_cand = '0; m_stable = '0; m_run = 1;
            m_in_ep = 1'b0; m_pend = 1'b0; m_ovf = 1'b0;
            exp_q.delete();
        end else begin
            if (clear) begin
                exp_q.delete();
                m_ovf = 1'b0;
            end else if (m_pend) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(m_pcode);
                else m_ovf = 1'b1;
            end
            m_pend = 1'b0;
            if (!m_in_ep && m_stable != 0) begin
                m_in_ep = 1'b1;
                m_pend  = 1'b1;
                m_pcode = lowest(m_stable);
            end else if (m_in_ep && m_stable == 0) begin
                m_in_ep = 1'b0;
            end
            if (m_d2 == m_cand) m_run++;
            else begin
                m_run  = 1;
                m_cand = m_d2;
            end
            if (m_run == DB) m_stable = m_cand;
            m_d2 = m_d1;
            m_d1 = keys;
        end
    end

    // Monitor: compare flags every cycle, head whenever valid, pop on handshake.
    always @(negedge clk) begin
        chk("valid", int'(key_valid), int'(exp_q.size() != 0));
        chk("full", int'(fifo_full), int'(exp_q.size() == DEPTH));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("held", int'(key_held), int'(m_stable != 0));
        if (exp_q.size() != 0) chk("head", int'(key_code), exp_q[0]);
        else chk("code_idle", int'(key_code), 0);
        if (rst_n && ack && !clear && exp_q.size() != 0) begin
            chk("pop", int'(key_code), exp_q[0]);
            void'(exp_q.pop_front());
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic settle();
        keys = '0;
        cyc(DB + 6);
    endtask

    task automatic press(input logic [15:0] k, input int h);
        keys = k;
        cyc(h);
        settle();
    endtask

    task automatic drain();
        ack = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc(1);
        ack = 1'b0;
        chk("drained", int'(key_valid), 0);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
    endtask

    initial begin
        int lat;
        int w;
        logic [15:0] k;
        int h, g;

        // 1: reset with a key held, then latency of the first code
        rst_n = 1'b0;
        keys  = 16'h0010;
        cyc(3);
        chk("rst_valid", int'(key_valid), 0);
        chk("rst_code", int'(key_code), 0);
        chk("rst_held", int'(key_held), 0);
        chk("rst_full", int'(fifo_full), 0);
        chk("rst_ovf", int'(overflow), 0);
        rst_n = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (key_valid) begin
                lat = i;
                break;
            end
        end
        chk("latency", lat, DB + 4);
        chk("t1_code", int'(key_code), 4);
        chk("t1_held", int'(key_held), 1);
        settle();
        drain();

        // 2: bounce shorter than the debounce window
        for (int i = 0; i < 10; i++) begin
            keys = (i % 2 == 0) ? 16'h0001 : 16'h0000;
            cyc(2);
        end
        settle();
        chk("bounce_held", int'(key_held), 0);
        chk("bounce_valid", int'(key_valid), 0);
        press(16'h0001, 8);
        chk("t2_valid", int'(key_valid), 1);
        chk("t2_code", int'(key_code), 0);
        drain();

        // 3: multi-key press, partial release, then a new press
        keys = 16'h8201;
        cyc(8);
        keys = 16'h8200;
        cyc(8);
        settle();
        chk("t3_code", int'(key_code), 0);
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        chk("t3_single", int'(key_valid), 0);
        press(16'h8000, 8);
        chk("t3_code15", int'(key_code), 15);
        drain();

        // 4: overflow, then clear
        pulse_clear();
        for (int n = 1; n <= 5; n++) press(16'(1 << n), 6);
        chk("t4_full", int'(fifo_full), 1);
        chk("t4_ovf", int'(overflow), 1);
        chk("t4_head", int'(key_code), 1);
        pulse_clear();
        chk("t4_clr_valid", int'(key_valid), 0);
        chk("t4_clr_ovf", int'(overflow), 0);

        // 5: push into a full FIFO coinciding with ack
        for (int n = 6; n <= 9; n++) press(16'(1 << n), 6);
        chk("t5_full", int'(fifo_full), 1);
        keys = 16'(1 << 10);
        w = 0;
        while (!m_pend && w < 30) begin
            cyc(1);
            w++;
        end
        if (w >= 30) begin
            failures++;
            $display("FAIL t5_push_wait: no push within %0d cycles", w);
        end
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        chk("t5_ovf", int'(overflow), 0);
        chk("t5_full_after", int'(fifo_full), 1);
        chk("t5_head", int'(key_code), 7);
        settle();

        // 6: ack while empty, then in-order handshake
        pulse_clear();
        ack = 1'b1;
        cyc(3);
        ack = 1'b0;
        chk("t6_empty_ack", int'(key_valid), 0);
        for (int n = 11; n <= 14; n++) press(16'(1 << n), 6);
        for (int j = 0; j < 4; j++) begin
            chk("t6_order", int'(key_code), 11 + j);
            ack = 1'b1;
            cyc(1);
            ack = 1'b0;
            cyc(1);
        end
        chk("t6_done", int'(key_valid), 0);

        // Random episodes with glitches, random acks/clears and one mid-run reset
        for (int ep = 0; ep < 40; ep++) begin
            k = 16'($urandom);
            if ($urandom_range(0, 2) == 0) k = 16'(1 << $urandom_range(0, 15));
            h = $urandom_range(1, 9);
            g = $urandom_range(1, 9);
            if (ep == 20) begin
                keys = k;
                #3;
                rst_n = 1'b0;
                cyc(2);
                rst_n = 1'b1;
            end
            for (int i = 0; i < h + g; i++) begin
                keys = (i < h) ? k : 16'h0000;
                if (i < h && $urandom_range(0, 7) == 0) keys = k ^ 16'(1 << $urandom_range(0, 15));
                ack   = ($urandom_range(0, 3) == 0);
                clear = ($urandom_range(0, 29) == 0);
                cyc(1);
            end
        end
        ack   = 1'b0;
        clear = 1'b0;
        settle();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
